// File: rtl/opx_seq_mux.sv
// opx_seq_mux: drives a registered OPX control bundle selected by instruction group, with stall hold,
// a one-entry pending load and an optional debug override built only when OPX_SEQ_MUX_DEBUG_EN is defined.
module opx_seq_mux #(
  parameter int GROUPS = 8,
  parameter int GW     = 3,
  parameter int BW     = 40
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [GW-1:0]        INSTRUCTION_GROUP,
  input  logic                 GROUP_LOAD,
  input  logic [GROUPS*BW-1:0] BUNDLES,
  input  logic [GROUPS-1:0]    GROUP_EN,
  input  logic [BW-1:0]        DEFAULT_BUNDLE,
  input  logic                 STALL,
  input  logic                 DBG_REQ,
  input  logic [GW-1:0]        DBG_GROUP,
  output logic [BW-1:0]        OPX,
  output logic [GW-1:0]        ACTIVE_GROUP,
  output logic                 OPX_VALID,
  output logic                 ILLEGAL,
  output logic                 OVERRUN
);
  localparam int NG = 1 << GW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
`ifdef OPX_SEQ_MUX_DEBUG_EN
    , S_DBG
`endif
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_opx;
  logic [GW-1:0]   r_grp;
  logic            r_vld;
  logic            r_ill;
  logic            r_ovr;
  logic            r_pvld;
  logic [GW-1:0]   r_pgrp;

  // Index space padded to 2^GW: groups past GROUPS read as disabled.
  logic [NG-1:0]   w_en;
  logic [BW-1:0]   w_bun [NG];

  for (genvar g = 0; g < NG; g++) begin : g_pad
    if (g < GROUPS) begin : g_real
      assign w_en[g]  = GROUP_EN[g];
      assign w_bun[g] = BUNDLES[g*BW +: BW];
    end else begin : g_void
      assign w_en[g]  = 1'b0;
      assign w_bun[g] = DEFAULT_BUNDLE;
    end
  end

  function automatic logic [BW-1:0] f_pick(input logic [GW-1:0] g);
    f_pick = w_en[g] ? w_bun[g] : DEFAULT_BUNDLE;
  endfunction

`ifdef OPX_SEQ_MUX_DEBUG_EN
  logic [GW-1:0]   r_sgrp;
  logic            r_svld;
  logic            w_dbg_go;
  assign w_dbg_go = DBG_REQ && (r_state == S_RUN || r_state == S_HOLD);
`else
  logic            w_unused_dbg;
  assign w_unused_dbg = ^{DBG_REQ, DBG_GROUP};
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_opx   <= DEFAULT_BUNDLE;
      r_grp   <= '0;
      r_vld   <= 1'b0;
      r_ill   <= 1'b0;
      r_ovr   <= 1'b0;
      r_pvld  <= 1'b0;
      r_pgrp  <= '0;
`ifdef OPX_SEQ_MUX_DEBUG_EN
      r_sgrp  <= '0;
      r_svld  <= 1'b0;
`endif
    end else begin
      r_ill <= 1'b0;
`ifdef OPX_SEQ_MUX_DEBUG_EN
      if (w_dbg_go) begin
        // Remember the running group so release can put it back before pending work.
        r_sgrp  <= r_grp;
        r_svld  <= r_vld;
        r_state <= S_DBG;
        r_opx   <= f_pick(DBG_GROUP);
        r_grp   <= DBG_GROUP;
        r_vld   <= 1'b1;
        r_ill   <= !w_en[DBG_GROUP];
        if (GROUP_LOAD) begin
          r_ovr  <= r_ovr | r_pvld;
          r_pvld <= 1'b1;
          r_pgrp <= INSTRUCTION_GROUP;
        end
      end else
`endif
      case (r_state)
        S_IDLE: begin
          r_opx <= DEFAULT_BUNDLE;
          r_vld <= 1'b0;
          if (GROUP_LOAD && !STALL) begin
            r_opx   <= f_pick(INSTRUCTION_GROUP);
            r_grp   <= INSTRUCTION_GROUP;
            r_vld   <= 1'b1;
            r_ill   <= !w_en[INSTRUCTION_GROUP];
            r_state <= S_RUN;
          end else if (GROUP_LOAD) begin
            r_pvld  <= 1'b1;
            r_pgrp  <= INSTRUCTION_GROUP;
            r_state <= S_HOLD;
          end
        end
        S_RUN: begin
          if (STALL) begin
            r_state <= S_HOLD;
            if (GROUP_LOAD) begin
              r_ovr  <= r_ovr | r_pvld;
              r_pvld <= 1'b1;
              r_pgrp <= INSTRUCTION_GROUP;
            end
          end else if (GROUP_LOAD) begin
            r_opx <= f_pick(INSTRUCTION_GROUP);
            r_grp <= INSTRUCTION_GROUP;
            r_vld <= 1'b1;
            r_ill <= !w_en[INSTRUCTION_GROUP];
          end else begin
            r_opx <= f_pick(r_grp);
          end
        end
        S_HOLD: begin
          if (STALL) begin
            if (GROUP_LOAD) begin
              r_ovr  <= r_ovr | r_pvld;
              r_pvld <= 1'b1;
              r_pgrp <= INSTRUCTION_GROUP;
            end
          end else if (GROUP_LOAD) begin
            // A fresh load supersedes whatever was pending; not an overrun.
            r_opx   <= f_pick(INSTRUCTION_GROUP);
            r_grp   <= INSTRUCTION_GROUP;
            r_vld   <= 1'b1;
            r_ill   <= !w_en[INSTRUCTION_GROUP];
            r_pvld  <= 1'b0;
            r_state <= S_RUN;
          end else if (r_pvld) begin
            r_opx   <= f_pick(r_pgrp);
            r_grp   <= r_pgrp;
            r_vld   <= 1'b1;
            r_ill   <= !w_en[r_pgrp];
            r_pvld  <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= r_vld ? S_RUN : S_IDLE;
          end
        end
`ifdef OPX_SEQ_MUX_DEBUG_EN
        S_DBG: begin
          if (DBG_REQ) begin
            r_opx <= f_pick(DBG_GROUP);
            r_grp <= DBG_GROUP;
            r_vld <= 1'b1;
            r_ill <= (DBG_GROUP != r_grp) && !w_en[DBG_GROUP];
          end else begin
            // Restore now; HOLD applies any pending entry on the next STALL-free cycle.
            r_opx   <= r_svld ? f_pick(r_sgrp) : DEFAULT_BUNDLE;
            r_grp   <= r_sgrp;
            r_vld   <= r_svld;
            r_state <= S_HOLD;
          end
          if (GROUP_LOAD) begin
            r_ovr  <= r_ovr | r_pvld;
            r_pvld <= 1'b1;
            r_pgrp <= INSTRUCTION_GROUP;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OPX          = r_opx;
  assign ACTIVE_GROUP = r_grp;
  assign OPX_VALID    = r_vld;
  assign ILLEGAL      = r_ill;
  assign OVERRUN      = r_ovr;
endmodule

// File: tb/tb_opx_seq_mux.sv
// Scoreboard bench for opx_seq_mux: an 8-group instance for sequencing and a 5-group instance for range checks.
module tb_opx_seq_mux;
  localparam int BW = 40;
  localparam int GW = 3;
`ifdef OPX_SEQ_MUX_DEBUG_EN
  localparam bit DBG_ON = 1'b1;
`else
  localparam bit DBG_ON = 1'b0;
`endif
  localparam logic [BW-1:0] DEF = 40'hDE_FA17_0001;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            GROUP_LOAD = 1'b0;
  logic            STALL = 1'b0;
  logic            DBG_REQ = 1'b0;
  logic [GW-1:0]   INSTRUCTION_GROUP = '0;
  logic [GW-1:0]   DBG_GROUP = '0;
  logic [8*BW-1:0] BUNDLES;
  logic [7:0]      GROUP_EN = 8'hFF;
  logic [BW-1:0]   DEFAULT_BUNDLE = DEF;

  logic [BW-1:0]   OPX, o5_opx;
  logic [GW-1:0]   ACTIVE_GROUP, o5_grp;
  logic            OPX_VALID, ILLEGAL, OVERRUN, o5_vld, o5_ill, o5_ovr;

  int n_run = 0;
  int n_fail = 0;
  logic [45:0] exp_q[$];

  always #5 CLK = ~CLK;

  opx_seq_mux #(.GROUPS(8), .GW(GW), .BW(BW)) u_dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION_GROUP(INSTRUCTION_GROUP), .GROUP_LOAD(GROUP_LOAD),
    .BUNDLES(BUNDLES), .GROUP_EN(GROUP_EN), .DEFAULT_BUNDLE(DEFAULT_BUNDLE), .STALL(STALL),
    .DBG_REQ(DBG_REQ), .DBG_GROUP(DBG_GROUP), .OPX(OPX), .ACTIVE_GROUP(ACTIVE_GROUP),
    .OPX_VALID(OPX_VALID), .ILLEGAL(ILLEGAL), .OVERRUN(OVERRUN));

  opx_seq_mux #(.GROUPS(5), .GW(GW), .BW(BW)) u_dut5 (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION_GROUP(INSTRUCTION_GROUP), .GROUP_LOAD(GROUP_LOAD),
    .BUNDLES(BUNDLES[5*BW-1:0]), .GROUP_EN(GROUP_EN[4:0]), .DEFAULT_BUNDLE(DEFAULT_BUNDLE), .STALL(STALL),
    .DBG_REQ(DBG_REQ), .DBG_GROUP(DBG_GROUP), .OPX(o5_opx), .ACTIVE_GROUP(o5_grp),
    .OPX_VALID(o5_vld), .ILLEGAL(o5_ill), .OVERRUN(o5_ovr));

  typedef struct packed {
    logic        rst, ld;
    logic [2:0]  g;
    logic        st, dbg;
    logic [2:0]  dg;
    logic [7:0]  en;
    logic [39:0] b3;
    logic [45:0] exp;
  } row_t;

  function automatic logic [BW-1:0] bv(input int g);
    if (g == 3) return 40'hA5;
    return {8'hB0 + 8'(g), 32'h1234_0000 + 32'(g)};
  endfunction

  // One cycle of stimulus plus the outputs required after the following edge.
  function automatic row_t r(input int rst, input int ld, input int g, input int st, input int dbg, input int dg,
                             input logic [39:0] opx, input int grp, input int vld, input int ill, input int ovr,
                             input logic [7:0] en = 8'hFF, input logic [39:0] b3 = 40'hA5);
    row_t x;
    x.rst = (rst != 0); x.ld = (ld != 0); x.g = 3'(g); x.st = (st != 0);
    x.dbg = (dbg != 0); x.dg = 3'(dg); x.en = en; x.b3 = b3;
    x.exp = {opx, 3'(grp), (vld != 0), (ill != 0), (ovr != 0)};
    return x;
  endfunction

  task automatic drive(input row_t x);
    RESET = x.rst; GROUP_LOAD = x.ld; INSTRUCTION_GROUP = x.g; STALL = x.st;
    DBG_REQ = x.dbg; DBG_GROUP = x.dg; GROUP_EN = x.en; BUNDLES[3*BW +: BW] = x.b3;
  endtask

  task automatic test_reset;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(1,1,5,1,1,7, DEF,0,0,0,0));
    t.push_back(r(1,0,0,0,0,0, DEF,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_load;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,0,0,0,0,0, DEF,0,0,0,0));
    t.push_back(r(0,1,3,0,0,0, bv(3),3,1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(3),3,1,0,0));
    t.push_back(r(0,1,1,0,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,1,3,0,0,0, bv(3),3,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL load[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_track;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,0,0,0,0,0, 40'h5A,3,1,0,0, 8'hFF, 40'h5A));
    t.push_back(r(0,0,0,0,0,0, 40'h5A,3,1,0,0, 8'hFF, 40'h5A));
    t.push_back(r(0,0,0,0,0,0, bv(3),3,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL track[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Checked on the 5-group instance: 6 is out of range, 2 is disabled via the mask.
  task automatic test_illegal;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,1,6,0,0,0, DEF,6,1,1,0));
    t.push_back(r(0,0,0,0,0,0, DEF,6,1,0,0));
    t.push_back(r(0,1,1,0,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,1,2,0,0,0, DEF,2,1,1,0, 8'hFB));
    t.push_back(r(0,0,0,0,0,0, DEF,2,1,0,0, 8'hFB));
    t.push_back(r(0,1,3,0,0,0, bv(3),3,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {o5_opx, o5_grp, o5_vld, o5_ill, o5_ovr}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL illegal[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Bundle 3 changes underneath the stall; OPX must stay frozen at the old value.
  task automatic test_stall;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,0,0,1,0,0, bv(3),3,1,0,0, 8'hFF, 40'h77));
    t.push_back(r(0,1,2,1,0,0, bv(3),3,1,0,0, 8'hFF, 40'h77));
    t.push_back(r(0,1,4,1,0,0, bv(3),3,1,0,1, 8'hFF, 40'h77));
    t.push_back(r(0,0,0,1,0,0, bv(3),3,1,0,1, 8'hFF, 40'h77));
    t.push_back(r(0,0,0,0,0,0, bv(4),4,1,0,1));
    t.push_back(r(0,0,0,0,0,0, bv(4),4,1,0,1));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stall[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_load_wins;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(1,0,0,0,0,0, DEF,0,0,0,0));
    t.push_back(r(0,1,1,0,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,1,5,1,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,1,2,0,0,0, bv(2),2,1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(2),2,1,0,0));
    t.push_back(r(0,0,0,1,0,0, bv(2),2,1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(2),2,1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(2),2,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL load_wins[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_dbg;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,1,1,0,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,0,0,0,1,7, DBG_ON ? bv(7) : bv(1), DBG_ON ? 7 : 1, 1,0,0));
    t.push_back(r(0,1,4,0,1,7, DBG_ON ? bv(7) : bv(4), DBG_ON ? 7 : 4, 1,0,0));
    t.push_back(r(0,0,0,0,1,7, DBG_ON ? bv(7) : bv(4), DBG_ON ? 7 : 4, 1,0,0));
    t.push_back(r(0,0,0,0,0,0, DBG_ON ? bv(1) : bv(4), DBG_ON ? 1 : 4, 1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(4),4,1,0,0));
    t.push_back(r(0,0,0,0,0,0, bv(4),4,1,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL dbg[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    row_t t[$];
    logic [45:0] e, a;
    t.push_back(r(0,0,0,1,0,0, bv(4),4,1,0,0));
    t.push_back(r(0,1,2,1,0,0, bv(4),4,1,0,0));
    t.push_back(r(1,0,0,1,0,0, DEF,0,0,0,0));
    t.push_back(r(0,0,0,0,0,0, DEF,0,0,0,0));
    t.push_back(r(0,0,0,0,0,0, DEF,0,0,0,0));
    t.push_back(r(0,1,1,0,0,0, bv(1),1,1,0,0));
    t.push_back(r(0,0,0,0,1,7, DBG_ON ? bv(7) : bv(1), DBG_ON ? 7 : 1, 1,0,0));
    t.push_back(r(1,0,0,0,1,7, DEF,0,0,0,0));
    t.push_back(r(0,0,0,0,1,7, DEF,0,0,0,0));
    t.push_back(r(0,0,0,0,0,0, DEF,0,0,0,0));
    foreach (t[i]) begin
      drive(t[i]); exp_q.push_back(t[i].exp);
      @(posedge CLK); #1;
      e = exp_q.pop_front(); a = {OPX, ACTIVE_GROUP, OPX_VALID, ILLEGAL, OVERRUN}; n_run++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got opx=%h grp=%0d v/i/o=%b%b%b want opx=%h grp=%0d v/i/o=%b%b%b",
                 i, a[45:6], a[5:3], a[2], a[1], a[0], e[45:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    for (int g = 0; g < 8; g++) BUNDLES[g*BW +: BW] = bv(g);
    test_reset;
    test_load;
    test_track;
    test_illegal;
    test_stall;
    test_load_wins;
    test_dbg;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/opx_seq_mux.md
OPX_SEQ_MUX -- requirements
Module: opx_seq_mux

Interface
REQ-001 Parameter GROUPS, default 8: number of instruction groups, 2..16.
REQ-002 Parameter GW, default 3: group index width; the design SHALL satisfy 2^GW >= GROUPS.
REQ-003 Parameter BW, default 40: width of one concatenated control bundle (ADDR_BUSX..REGB_ADDRX).
REQ-004 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 INSTRUCTION_GROUP  in  GW  group index of the instruction being decoded.
REQ-007 GROUP_LOAD  in  1  one-cycle strobe; captures INSTRUCTION_GROUP.
REQ-008 BUNDLES  in  GROUPS*BW  per-group control bundles; group g occupies bits [g*BW +: BW].
REQ-009 GROUP_EN  in  GROUPS  per-group enable mask.
REQ-010 DEFAULT_BUNDLE  in  BW  safe (SYS-equivalent) bundle.
REQ-011 STALL  in  1  freezes the outputs.
REQ-012 DBG_REQ  in  1  debug override request.
REQ-013 DBG_GROUP  in  GW  group forced during debug.
REQ-014 OPX  out  BW  registered selected bundle.
REQ-015 ACTIVE_GROUP  out  GW  currently selected group.
REQ-016 OPX_VALID  out  1  OPX reflects a loaded group.
REQ-017 ILLEGAL  out  1  one-cycle pulse when an out-of-range or disabled group is applied.
REQ-018 OVERRUN  out  1  sticky flag; a pending load was overwritten.

Function
REQ-019 FSM states SHALL be IDLE, RUN, HOLD and DBG.
REQ-020 IDLE: OPX=DEFAULT_BUNDLE, OPX_VALID=0; GROUP_LOAD with STALL=0 SHALL go to RUN.
REQ-021 Applying group g SHALL register OPX=BUNDLES[g] one cycle after the load edge (latency 1), set ACTIVE_GROUP=g and set OPX_VALID=1.
REQ-022 If g>=GROUPS or GROUP_EN[g]=0: OPX=DEFAULT_BUNDLE, ACTIVE_GROUP=g, OPX_VALID=1 and ILLEGAL pulses for exactly one cycle.
REQ-023 RUN: while ACTIVE_GROUP is unchanged, OPX SHALL track BUNDLES[ACTIVE_GROUP] with a one-cycle register delay.
REQ-024 STALL=1 in RUN SHALL go to HOLD; HOLD freezes OPX, ACTIVE_GROUP and OPX_VALID.
REQ-025 GROUP_LOAD during HOLD (or coincident with STALL) SHALL be captured in a one-entry pending register.
REQ-026 A second load while pending is full SHALL overwrite the pending entry and set OVERRUN.
REQ-027 Leaving HOLD (STALL=0) SHALL apply the pending group in that cycle, clear the pending entry and return to RUN; with nothing pending it SHALL return to RUN unchanged.
REQ-028 GROUP_LOAD and STALL=0 in the same cycle as pending-apply: the new load wins and the pending entry is discarded without setting OVERRUN.
REQ-029 DBG_REQ=1 in any non-IDLE state SHALL enter DBG: OPX=BUNDLES[DBG_GROUP] (legality rules per REQ-022), ignoring STALL.
REQ-030 In DBG, loads SHALL go to the pending register.
REQ-031 On DBG_REQ falling, the FSM SHALL restore the pre-debug group, then apply any pending entry per REQ-027.
REQ-032 OVERRUN SHALL clear only on RESET.

Reset
REQ-033 RESET SHALL force IDLE, OPX=DEFAULT_BUNDLE, ACTIVE_GROUP=0, OPX_VALID=0, ILLEGAL=0, OVERRUN=0 and pending empty, on the next edge.
REQ-034 RESET SHALL take priority over all other inputs, including in mid-HOLD or mid-DBG.

Configuration
REQ-035 Macro OPX_SEQ_MUX_DEBUG_EN SHALL control the debug override.
REQ-036 Defined: DBG state and REQ-029..REQ-031 are present.
REQ-037 Undefined: the DBG state is not built, DBG_REQ and DBG_GROUP are ignored, and the port list is unchanged.

Verification
REQ-038 RESET, then load group 3 with BUNDLES[3]=0xA5 -> OPX=0xA5 one cycle later; OPX_VALID=1; ACTIVE_GROUP=3.
REQ-039 GROUPS=5, load group 6 -> OPX=DEFAULT_BUNDLE and ILLEGAL high for exactly 1 cycle; repeat with GROUP_EN[2]=0 and group 2 -> same response.
REQ-040 STALL=1 for 4 cycles; load 2 then 4 during the stall -> OPX frozen throughout; OVERRUN=1; group 4 applied on the first cycle with STALL=0.
REQ-041 RUN on group 1, assert DBG_REQ with DBG_GROUP=7 for 3 cycles -> OPX=BUNDLES[7]; after release OPX=BUNDLES[1]; with the macro undefined OPX stays BUNDLES[1] throughout.
REQ-042 Assert RESET in mid-HOLD with a pending load -> all outputs at reset values next cycle; the pending load is never applied.
